// File: rtl/pll_rst_seq_pkg.sv
// pll_rst_seq_pkg: shared state encoding and counter sizing for the PLL reset sequencer
package pll_rst_seq_pkg;
  typedef enum logic [2:0] {
    ST_PWRDN,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_e;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/pll_rst_seq_if.sv
// pll_rst_seq_if: PLL control/status and downstream reset signals of the sequencer
interface pll_rst_seq_if;
  logic       pll_locked;
  logic       req_reset;
  logic       pwrdwn_req;
  logic       pll_rst;
  logic       pll_pwrdwn;
  logic       sys_rst;
  logic       locked_out;
  logic       timeout_err;
  logic [3:0] retry_cnt;
  modport slave (
    input  pll_locked, req_reset, pwrdwn_req,
    output pll_rst, pll_pwrdwn, sys_rst, locked_out, timeout_err, retry_cnt
  );
  modport master (
    output pll_locked, req_reset, pwrdwn_req,
    input  pll_rst, pll_pwrdwn, sys_rst, locked_out, timeout_err, retry_cnt
  );
endinterface

// File: rtl/pll_rst_seq_sync_bit.sv
// sync_bit: multi-flop synchronizer for a single asynchronous level, clears to 0 on reset
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: drives PLL reset/power-down, retries lock on timeout, releases SYS_RST after stable lock
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES       = 256,
  parameter int MAX_RETRIES         = 4,
  parameter int SYNC_STAGES         = 2
) (
  input logic           clk,
  input logic           rst,
  pll_rst_seq_if.slave  bus
);
  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam logic [CW-1:0] PULSE_END = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TO_END    = CW'(LOCK_TIMEOUT_CYCLES - 1);
  // the sample that moves WAIT_LOCK into STABLE is the first of the stable run
  localparam logic [CW-1:0] STB_END   = CW'(STABLE_CYCLES - 2);
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d, retry_inc;
  logic            req_q, lk, rise, restart;
  logic            pll_rst_q, pwrdwn_q, sys_rst_q, locked_q, err_q;
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.pll_locked),
    .q_o (lk)
  );
  assign rise      = bus.req_reset & ~req_q;
  assign retry_inc = retry_q + 4'd1;
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    restart = 1'b0;
    if (bus.pwrdwn_req) state_d = ST_PWRDN;
    else if (state_q == ST_PWRDN || rise) begin
      state_d = ST_RESET;
      retry_d = '0;
      restart = 1'b1;
    end else begin
      case (state_q)
        ST_RESET:     state_d = (cnt_q == PULSE_END) ? ST_WAIT_LOCK : ST_RESET;
        ST_WAIT_LOCK: begin
          if (lk) state_d = ST_STABLE;
          else if (cnt_q == TO_END) begin
            retry_d = retry_inc;
            state_d = (retry_inc == 4'(MAX_RETRIES)) ? ST_FAIL : ST_RESET;
          end
        end
        ST_STABLE: begin
          if (!lk) state_d = ST_WAIT_LOCK;
          else if (cnt_q == STB_END) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN:       state_d = lk ? ST_RUN : ST_RESET;
        default:      state_d = state_q;
      endcase
    end
  end
  assign cnt_d = (restart || state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + CW'(1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      retry_q   <= '0;
      req_q     <= 1'b0;
      pll_rst_q <= 1'b1;
      pwrdwn_q  <= 1'b0;
      sys_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      req_q     <= bus.req_reset;
      pll_rst_q <= state_d inside {ST_RESET, ST_FAIL, ST_PWRDN};
      pwrdwn_q  <= state_d == ST_PWRDN;
      sys_rst_q <= state_d != ST_RUN;
      locked_q  <= state_d == ST_RUN;
      err_q     <= state_d == ST_FAIL;
    end
  assign bus.pll_rst     = pll_rst_q;
  assign bus.pll_pwrdwn  = pwrdwn_q;
  assign bus.sys_rst     = sys_rst_q;
  assign bus.locked_out  = locked_q;
  assign bus.timeout_err = err_q;
  assign bus.retry_cnt   = retry_q;
endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: directed vector table, async-reset sequence and random run against a phase-level model
module tb_pll_rst_seq;
  localparam int P  = 4;
  localparam int T  = 32;
  localparam int S  = 8;
  localparam int MR = 2;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  pll_rst_seq_if bus ();
  pll_rst_seq #(
    .RST_PULSE_CYCLES    (P),
    .LOCK_TIMEOUT_CYCLES (T),
    .STABLE_CYCLES       (S),
    .MAX_RETRIES         (MR),
    .SYNC_STAGES         (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  typedef enum {M_PD, M_PULSE, M_SEEK, M_RUN, M_FAIL} ph_e;
  ph_e ph;
  int  pulse_n, streak, lows, retries;
  bit  req_prev;
  bit  lk_h [SS];
  typedef struct {
    int r, e, lk, rq, pd, prst, pwd, sys, lo, te, rc;
  } vec_t;
  vec_t tbl [$];
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n, act, exp);
    end
  endtask
  task automatic model_reset();
    ph = M_PULSE;
    pulse_n = 0;
    streak = 0;
    lows = 0;
    retries = 0;
    req_prev = 1'b0;
    for (int i = 0; i < SS; i++) lk_h[i] = 1'b0;
  endtask
  // phase-level view: PULSE counts reset cycles, SEEK tracks the lk-high streak and the lk-low run
  task automatic model_step();
    bit lk, rise;
    lk = lk_h[SS-1];
    for (int i = SS - 1; i > 0; i--) lk_h[i] = lk_h[i-1];
    lk_h[0] = bus.pll_locked;
    rise = bus.req_reset && !req_prev;
    req_prev = bus.req_reset;
    if (bus.pwrdwn_req) ph = M_PD;
    else if (ph == M_PD || rise) begin
      ph = M_PULSE;
      pulse_n = 0;
      retries = 0;
    end else if (ph == M_PULSE) begin
      pulse_n++;
      if (pulse_n == P) begin
        ph = M_SEEK;
        streak = 0;
        lows = 0;
      end
    end else if (ph == M_SEEK) begin
      if (lk) begin
        streak++;
        lows = 0;
        if (streak == S) begin
          ph = M_RUN;
          retries = 0;
        end
      end else if (streak > 0) begin
        streak = 0;
        lows = 0;
      end else begin
        lows++;
        if (lows == T) begin
          retries++;
          if (retries == MR) ph = M_FAIL;
          else begin
            ph = M_PULSE;
            pulse_n = 0;
          end
        end
      end
    end else if (ph == M_RUN && !lk) begin
      ph = M_PULSE;
      pulse_n = 0;
    end
  endtask
  task automatic compare_model();
    check("m_pll_rst", 4'(bus.pll_rst), 4'(ph inside {M_PD, M_PULSE, M_FAIL}));
    check("m_pwrdwn", 4'(bus.pll_pwrdwn), 4'(ph == M_PD));
    check("m_sys_rst", 4'(bus.sys_rst), 4'(ph != M_RUN));
    check("m_locked", 4'(bus.locked_out), 4'(ph == M_RUN));
    check("m_tmo_err", 4'(bus.timeout_err), 4'(ph == M_FAIL));
    check("m_retry", bus.retry_cnt, 4'(retries));
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_rst"}, 4'(bus.pll_rst), 4'd1);
    check({tag, "_pwrdwn"}, 4'(bus.pll_pwrdwn), 4'd0);
    check({tag, "_sys_rst"}, 4'(bus.sys_rst), 4'd1);
    check({tag, "_locked"}, 4'(bus.locked_out), 4'd0);
    check({tag, "_tmo_err"}, 4'(bus.timeout_err), 4'd0);
    check({tag, "_retry"}, bus.retry_cnt, 4'd0);
  endtask
  task automatic step();
    @(posedge clk);
    edge_n++;
    if (rst) model_reset();
    else model_step();
    #1;
    compare_model();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.req_reset = 1'b0;
    bus.pwrdwn_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    edge_n = 0;
    check_reset_vals("rst");
  endtask
  initial begin
    int mode;
    bus.pll_locked = 1'b0;
    bus.req_reset = 1'b0;
    bus.pwrdwn_req = 1'b0;
    //         r  e   lk rq pd prst pwd sys lo te rc
    tbl = '{'{1,  3, 0, 0, 0, 1, 0, 1, 0, 0, 0},
            '{0,  4, 0, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 19, 1, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 20, 1, 0, 0, 0, 0, 0, 1, 0, 0},
            '{0, 22, 0, 0, 0, 0, 0, 0, 1, 0, 0},
            '{0, 23, 0, 0, 0, 1, 0, 1, 0, 0, 0},
            '{0, 24, 0, 0, 1, 1, 1, 1, 0, 0, 0},
            '{0, 30, 0, 0, 1, 1, 1, 1, 0, 0, 0},
            '{0, 31, 0, 0, 0, 1, 0, 1, 0, 0, 0},
            '{0, 34, 0, 0, 0, 1, 0, 1, 0, 0, 0},
            '{0, 35, 0, 0, 0, 0, 0, 1, 0, 0, 0},
            '{1, 35, 0, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 36, 0, 0, 0, 1, 0, 1, 0, 0, 1},
            '{0, 40, 0, 0, 0, 0, 0, 1, 0, 0, 1},
            '{0, 71, 0, 0, 0, 0, 0, 1, 0, 0, 1},
            '{0, 72, 0, 0, 0, 1, 0, 1, 0, 1, 2},
            '{0, 80, 0, 0, 0, 1, 0, 1, 0, 1, 2},
            '{0, 81, 1, 1, 0, 1, 0, 1, 0, 0, 0},
            '{0, 84, 1, 1, 0, 1, 0, 1, 0, 0, 0},
            '{0, 85, 1, 1, 0, 0, 0, 1, 0, 0, 0},
            '{0, 92, 1, 1, 0, 0, 0, 1, 0, 0, 0},
            '{0, 93, 1, 1, 0, 0, 0, 0, 1, 0, 0},
            '{0, 95, 1, 0, 0, 0, 0, 0, 1, 0, 0},
            '{1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 15, 1, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 16, 0, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 25, 1, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 26, 1, 0, 0, 0, 0, 0, 1, 0, 0}};
    foreach (tbl[k]) begin
      if (tbl[k].r != 0) do_reset();
      bus.pll_locked = tbl[k].lk[0];
      bus.req_reset = tbl[k].rq[0];
      bus.pwrdwn_req = tbl[k].pd[0];
      while (edge_n < tbl[k].e) step();
      check($sformatf("vec%0d_pll_rst", k), 4'(bus.pll_rst), 4'(tbl[k].prst));
      check($sformatf("vec%0d_pwrdwn", k), 4'(bus.pll_pwrdwn), 4'(tbl[k].pwd));
      check($sformatf("vec%0d_sys_rst", k), 4'(bus.sys_rst), 4'(tbl[k].sys));
      check($sformatf("vec%0d_locked", k), 4'(bus.locked_out), 4'(tbl[k].lo));
      check($sformatf("vec%0d_tmo_err", k), 4'(bus.timeout_err), 4'(tbl[k].te));
      check($sformatf("vec%0d_retry", k), bus.retry_cnt, 4'(tbl[k].rc));
    end
    do_reset();
    while (edge_n < 45) step();
    check("pre_async_pll_rst", 4'(bus.pll_rst), 4'd0);
    check("pre_async_retry", bus.retry_cnt, 4'd1);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("async");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    edge_n = 0;
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) mode = $urandom_range(0, 2);
      if (mode == 0 && $urandom_range(0, 99) < 4) bus.pll_locked = ~bus.pll_locked;
      if (mode == 1) bus.pll_locked = 1'b0;
      if (mode == 2) bus.pll_locked = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 99) < 2) bus.req_reset = ~bus.req_reset;
      if (!bus.pwrdwn_req && $urandom_range(0, 499) == 0) bus.pwrdwn_req = 1'b1;
      else if (bus.pwrdwn_req && $urandom_range(0, 9) == 0) bus.pwrdwn_req = 1'b0;
      rst = ($urandom_range(0, 999) < 2);
      step();
    end
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
